// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared states and constants for the I2S ADC capture path
package i2s_pkg;

  typedef enum logic [1:0] {SEEK, DELAY, SHIFT, HOLD} state_e;

  localparam logic LEFT           = 1'b0;
  localparam logic RIGHT          = 1'b1;
  localparam int   MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - synchronizer and rising-edge strobe for one clock-like input
// plus auxiliary inputs sampled from the same stage on that edge.
module i2s_sync_edge #(
  parameter int STAGES = 2,
  parameter int AUX_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edge_in,
  input  logic [AUX_W-1:0] aux_in,
  output logic             rise,
  output logic [AUX_W-1:0] aux_out
);

  logic [AUX_W:0]   sync_q [STAGES];
  logic [AUX_W:0]   sync_d [STAGES];
  logic [AUX_W:0]   last;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic [AUX_W-1:0] aux_q, aux_d;

  always_comb begin
    sync_d[0] = {aux_in, edge_in};
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    last   = sync_q[STAGES-1];
    prev_d = last[0];
    rise_d = last[0] & ~prev_q;
    // aux is captured alongside the strobe so both appear in the same cycle
    aux_d  = rise_d ? last[AUX_W:1] : aux_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      aux_q  <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q <= prev_d;
      rise_q <= rise_d;
      aux_q  <= aux_d;
    end
  end

  assign rise    = rise_q;
  assign aux_out = aux_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - I2S ADC deserializer with valid/ready pair output and sticky flags.
// Optional peak-magnitude tracking under I2S_RX_PEAK_EN.
module i2s_adc_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  sample_ready,
  input  logic                  clear_flags,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  sample_valid,
  output logic                  overrun,
  output logic                  frame_err
`ifdef I2S_RX_PEAK_EN
  ,
  output logic [DATA_WIDTH-2:0] peak_l,
  output logic [DATA_WIDTH-2:0] peak_r
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic                  bclk_rise;
  logic [1:0]            aux;
  logic                  lr, dat;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, shifted;
  logic                  chan_q, chan_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  left_ok_q, left_ok_d;
  logic [DATA_WIDTH-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  publish, frame_set, load;

  i2s_sync_edge #(
    .STAGES (SYNC_STAGES),
    .AUX_W  (2)
  ) u_sync (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .edge_in (AUD_BCLK),
    .aux_in  ({AUD_ADCLRCK, AUD_ADCDAT}),
    .rise    (bclk_rise),
    .aux_out (aux)
  );

  assign lr  = aux[1];
  assign dat = aux[0];

  // The edge that first shows a new LRCK level is the I2S delay bit; it moves
  // the FSM into DELAY, and the edge taken in DELAY carries the MSB.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    chan_d      = chan_q;
    lr_prev_d   = lr_prev_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    publish     = 1'b0;
    frame_set   = 1'b0;
    shifted     = {sr_q[DATA_WIDTH-2:0], dat};
    if (bclk_rise) begin
      lr_prev_d = lr;
      if (state_q == SEEK) begin
        if (lr_prev_q && !lr) begin
          state_d   = DELAY;
          chan_d    = LEFT;
          bit_cnt_d = '0;
          left_ok_d = 1'b0;
        end
      end else if (lr != lr_prev_q) begin
        frame_set = (state_q == SHIFT);
        state_d   = DELAY;
        chan_d    = lr;
        bit_cnt_d = '0;
        if (state_q == SHIFT || lr == LEFT) left_ok_d = 1'b0;
      end else begin
        case (state_q)
          DELAY: begin
            sr_d      = shifted;
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
          end
          SHIFT: begin
            sr_d      = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_d == CNT_W'(DATA_WIDTH)) begin
              state_d = HOLD;
              if (chan_q == LEFT) begin
                left_hold_d = shifted;
                left_ok_d   = 1'b1;
              end else begin
                publish   = left_ok_q;
                left_ok_d = 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    load        = publish & (~valid_q | sample_ready);
    valid_d     = load | (valid_q & ~sample_ready);
    sample_l_d  = load ? left_hold_q : sample_l_q;
    sample_r_d  = load ? shifted : sample_r_q;
    overrun_d   = (publish & ~load) | (overrun_q & ~clear_flags);
    frame_err_d = frame_set | (frame_err_q & ~clear_flags);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEEK;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      chan_q      <= LEFT;
      lr_prev_q   <= 1'b0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      sample_l_q  <= '0;
      sample_r_q  <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      chan_q      <= chan_d;
      lr_prev_q   <= lr_prev_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      sample_l_q  <= sample_l_d;
      sample_r_q  <= sample_r_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

`ifdef I2S_RX_PEAK_EN
  logic [DATA_WIDTH-2:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic [DATA_WIDTH-2:0] mag_l, mag_r;

  // |x| in DATA_WIDTH-1 bits; the most negative code saturates to all-ones
  function automatic logic [DATA_WIDTH-2:0] mag_sat(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] m;
    m = x[DATA_WIDTH-1] ? (~x + DATA_WIDTH'(1)) : x;
    return m[DATA_WIDTH-1] ? '1 : m[DATA_WIDTH-2:0];
  endfunction

  always_comb begin
    mag_l    = mag_sat(left_hold_q);
    mag_r    = mag_sat(shifted);
    peak_l_d = clear_flags ? '0 : peak_l_q;
    peak_r_d = clear_flags ? '0 : peak_r_q;
    if (load && mag_l > peak_l_d) peak_l_d = mag_l;
    if (load && mag_r > peak_r_d) peak_r_d = mag_r;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_l = peak_l_q;
  assign peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb/tb_i2s_adc_rx.sv - directed and random I2S frames against a frame-level reference model
module tb_i2s_adc_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          bclk = 1'b0, lrck = 1'b0, dat = 1'b0;
  logic          sample_ready = 1'b0, clear_flags = 1'b0;
  logic [DW-1:0] sample_l, sample_r;
  logic          sample_valid, overrun, frame_err;
`ifdef I2S_RX_PEAK_EN
  logic [DW-2:0] peak_l, peak_r;
`endif

  i2s_adc_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .AUD_BCLK     (bclk),
    .AUD_ADCLRCK  (lrck),
    .AUD_ADCDAT   (dat),
    .sample_ready (sample_ready),
    .clear_flags  (clear_flags),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .frame_err    (frame_err)
`ifdef I2S_RX_PEAK_EN
    ,
    .peak_l       (peak_l),
    .peak_r       (peak_r)
`endif
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  // reference model state: frame-level view of the stream
  logic        m_valid, m_ovr, m_ferr, m_synced, m_prev_lr, m_prev_short, m_left_ok;
  logic [31:0] m_pair;
  logic [15:0] m_left;
  logic [14:0] m_peak_l, m_peak_r;

  always @(negedge clk)
    if (reset_n && sample_valid && sample_ready) got_q.push_back({sample_l, sample_r});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [14:0] mag(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return 15'(s);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_synced = 0; m_prev_lr = 0;
    m_prev_short = 0; m_left_ok = 0; m_pair = '0; m_left = '0;
    m_peak_l = '0; m_peak_r = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one channel of nclk bit periods: delay bit, then DW bits MSB first, then zero padding
  task automatic send_chan(input logic lr, input logic [15:0] v, input int nclk);
    for (int i = 0; i < nclk; i++) begin
      bclk = 1'b0;
      lrck = lr;
      dat  = (i >= 1 && i <= DW) ? v[DW-i] : 1'b0;
      cyc(8);
      bclk = 1'b1;
      cyc(8);
    end
  endtask

  task automatic publish(input logic [31:0] p);
    if (m_valid && !sample_ready) m_ovr = 1;
    else begin
      m_pair = p;
      if (mag(p[31:16]) > m_peak_l) m_peak_l = mag(p[31:16]);
      if (mag(p[15:0]) > m_peak_r) m_peak_r = mag(p[15:0]);
      if (sample_ready) exp_q.push_back(p);
      else m_valid = 1;
    end
  endtask

  task automatic drive_chan(input logic lr, input logic [15:0] v, input int nclk);
    logic short_ch;
    short_ch = (nclk - 1) < DW;
    if (lr != m_prev_lr) begin
      if (m_synced && m_prev_short) m_ferr = 1;
      if (m_prev_lr && !lr) m_synced = 1;
    end
    m_prev_lr = lr;
    send_chan(lr, v, nclk);
    if (m_synced) begin
      m_prev_short = short_ch;
      if (!lr) begin
        m_left_ok = !short_ch;
        m_left    = v;
      end else begin
        if (m_left_ok && !short_ch) publish({m_left, v});
        m_left_ok = 0;
      end
    end
  endtask

  task automatic drive_frame(input logic [15:0] l, input logic [15:0] r);
    drive_chan(1'b0, l, 32);
    drive_chan(1'b1, r, 32);
  endtask

  task automatic pulse_ready();
    sample_ready = 1'b1;
    cyc(1);
    sample_ready = 1'b0;
    if (m_valid) exp_q.push_back(m_pair);
    m_valid = 0;
  endtask

  task automatic do_clear();
    clear_flags = 1'b1;
    cyc(1);
    clear_flags = 1'b0;
    m_ovr = 0; m_ferr = 0; m_peak_l = '0; m_peak_r = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(sample_valid), 32'(m_valid));
    check({tag, "_pair"}, {sample_l, sample_r}, m_pair);
    check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
`ifdef I2S_RX_PEAK_EN
    check({tag, "_peak_l"}, 32'(peak_l), 32'(m_peak_l));
    check({tag, "_peak_r"}, 32'(peak_r), 32'(m_peak_r));
`endif
  endtask

  task automatic check_transfers(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_xfer"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    model_reset();
    cyc(5);
    check_outputs("reset");
    reset_n = 1'b1;
    cyc(2);

    // basic frame with ready held high
    sample_ready = 1'b1;
    drive_chan(1'b1, 16'h0000, 4);
    drive_frame(16'hA5A5, 16'h1234);
    check_transfers("t1");
    check_outputs("t1");
    check("t1_l_const", 32'(sample_l), 32'h0000_A5A5);
    check("t1_r_const", 32'(sample_r), 32'h0000_1234);

    // back-pressure: second pair dropped, first pair held
    sample_ready = 1'b0;
    drive_frame(16'h0001, 16'h0002);
    drive_frame(16'h0003, 16'h0004);
    check_outputs("t2_hold");
    check("t2_overrun_const", 32'(overrun), 32'd1);
    pulse_ready();
    cyc(2);
    check_outputs("t2_after");
    check_transfers("t2");
    do_clear();
    check_outputs("t2_clr");

    // right channel cut short after 8 bits
    sample_ready = 1'b1;
    drive_chan(1'b0, 16'h5555, 32);
    drive_chan(1'b1, 16'h2222, 9);
    drive_frame(16'h7FFF, 16'h8000);
    check_outputs("t3");
    check("t3_ferr_const", 32'(frame_err), 32'd1);
    check_transfers("t3");
    do_clear();

    // reset mid-left, released mid-right
    drive_chan(1'b0, 16'h4444, 10);
    reset_n = 1'b0;
    send_chan(1'b0, 16'h4444, 6);
    send_chan(1'b1, 16'h5555, 6);
    model_reset();
    check_outputs("t4_rst");
    reset_n = 1'b1;
    drive_chan(1'b1, 16'h5555, 10);
    drive_frame(16'h1357, 16'h2468);
    check_transfers("t4");
    check_outputs("t4");

    // capture starting with LRCK already high: full right frame must be ignored
    reset_n = 1'b0;
    cyc(3);
    model_reset();
    reset_n = 1'b1;
    drive_chan(1'b1, 16'h6666, 32);
    drive_frame(16'h0F0F, 16'hF0F0);
    check_transfers("t5");
    check_outputs("t5");

    // random frames
    for (int k = 0; k < 6; k++) begin
      drive_frame(16'($urandom), 16'($urandom));
      check_transfers("rand");
    end
    check_outputs("rand");

`ifdef I2S_RX_PEAK_EN
    do_clear();
    drive_frame(16'h0100, 16'h0000);
    check("pk1", 32'(peak_l), 32'h0100);
    drive_frame(16'hF000, 16'h0000);
    check("pk2", 32'(peak_l), 32'h1000);
    drive_frame(16'h8000, 16'h0000);
    check("pk3", 32'(peak_l), 32'h7FFF);
    check_outputs("pk");
    do_clear();
    check("pk_clr", 32'(peak_l), 32'h0);
    check_transfers("pk");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
